// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - round-robin sequencer of multi-byte SPI transactions onto one shared spi_master
module spi_txn_arbiter #(
    parameter int NREQ     = 2,
    parameter int LENW     = 4,
    parameter int SS_SETUP = 2,
    parameter int SS_HOLD  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LENW-1:0] req_len,
    input  logic [NREQ*2-1:0]    req_mode,
    input  logic [NREQ*8-1:0]    tx_data,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      tx_ack,
    output logic [NREQ-1:0]      rx_valid,
    output logic [7:0]           rx_data,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      ss_n,
    output logic                 spi_cpol,
    output logic                 spi_cpha,
    output logic [7:0]           spi_din,
    output logic                 spi_start,
    input  logic                 spi_busy,
    input  logic [7:0]           spi_dout
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(2*SS_SETUP + SS_HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_LOAD, S_WAIT_BUSY, S_SHIFT, S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   tx_ack_q, tx_ack_d;
    logic [NREQ-1:0]   rx_valid_q, rx_valid_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   ss_n_q, ss_n_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic [7:0]        din_q, din_d;
    logic              start_q, start_d;
    logic [LENW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [IW-1:0]     ptr_q, ptr_d;

    logic [IW-1:0]     win_idx;
    logic [IW-1:0]     cand;
    logic [LENW-1:0]   win_len;
    logic [1:0]        win_mode;
    logic              start_txn;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        return NREQ'(1) << i;
    endfunction

    // Scan from farthest to nearest after the pointer so the nearest pending request wins.
    always_comb begin
        win_idx = ptr_q;
        cand    = ptr_q;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(ptr_q) + k) % NREQ);
            if (req[cand]) begin
                win_idx = cand;
            end
        end
    end

    assign win_len   = req_len[win_idx*LENW +: LENW];
    assign win_mode  = req_mode[win_idx*2 +: 2];
    assign start_txn = (state_q == S_IDLE) && !spi_busy && (|req);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            tx_ack_q   <= '0;
            rx_valid_q <= '0;
            rx_data_q  <= '0;
            done_q     <= '0;
            ss_n_q     <= '1;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            din_q      <= '0;
            start_q    <= 1'b0;
            cnt_q      <= '0;
            tmr_q      <= '0;
            gidx_q     <= '0;
            ptr_q      <= IW'(NREQ - 1);
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            tx_ack_q   <= tx_ack_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            done_q     <= done_d;
            ss_n_q     <= ss_n_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            din_q      <= din_d;
            start_q    <= start_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            gidx_q     <= gidx_d;
            ptr_q      <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start_txn) state_d = (win_len == '0) ? S_IDLE : S_SETUP;
            S_SETUP:     if (tmr_q == TW'(2*SS_SETUP - 2)) state_d = S_LOAD;
            S_LOAD:      state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (spi_busy) state_d = S_SHIFT;
            S_SHIFT:     if (!spi_busy) state_d = (cnt_q == LENW'(1)) ? S_HOLD : S_LOAD;
            S_HOLD:      if (tmr_q == TW'(SS_HOLD - 1)) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_d    = grant_q;
        tx_ack_d   = '0;
        rx_valid_d = '0;
        rx_data_d  = rx_data_q;
        done_d     = '0;
        ss_n_d     = ss_n_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        din_d      = din_q;
        start_d    = start_q;
        cnt_d      = cnt_q;
        tmr_d      = tmr_q;
        gidx_d     = gidx_q;
        ptr_d      = ptr_q;
        case (state_q)
            S_IDLE: begin
                // A zero-length grant lasts one cycle, so grant is cleared on every idle cycle.
                grant_d = '0;
                tmr_d   = '0;
                if (start_txn) begin
                    grant_d = onehot(win_idx);
                    cpol_d  = win_mode[1];
                    cpha_d  = win_mode[0];
                    cnt_d   = win_len;
                    ptr_d   = win_idx;
                    gidx_d  = win_idx;
                    if (win_len == '0) begin
                        done_d = onehot(win_idx);
                    end
                end
            end
            S_SETUP: begin
                tmr_d = tmr_q + TW'(1);
                if (tmr_q == TW'(SS_SETUP - 1)) begin
                    ss_n_d[gidx_q] = 1'b0;
                end
                if (tmr_q == TW'(2*SS_SETUP - 2)) begin
                    tmr_d = '0;
                end
            end
            S_LOAD: begin
                din_d    = tx_data[gidx_q*8 +: 8];
                start_d  = 1'b1;
                tx_ack_d = onehot(gidx_q);
            end
            S_WAIT_BUSY: begin
                if (spi_busy) begin
                    start_d = 1'b0;
                end
            end
            S_SHIFT: begin
                tmr_d = '0;
                if (!spi_busy) begin
                    rx_data_d  = spi_dout;
                    rx_valid_d = onehot(gidx_q);
                    cnt_d      = cnt_q - LENW'(1);
                end
            end
            S_HOLD: begin
                tmr_d = tmr_q + TW'(1);
                if (tmr_q == TW'(SS_HOLD - 1)) begin
                    ss_n_d  = '1;
                    done_d  = onehot(gidx_q);
                    grant_d = '0;
                    tmr_d   = '0;
                end
            end
            default: begin
                grant_d = '0;
            end
        endcase
    end

    assign grant     = grant_q;
    assign tx_ack    = tx_ack_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign done      = done_q;
    assign ss_n      = ss_n_q;
    assign spi_cpol  = cpol_q;
    assign spi_cpha  = cpha_q;
    assign spi_din   = din_q;
    assign spi_start = start_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb/tb_spi_txn_arbiter.sv - randomized bench for spi_txn_arbiter against a transaction-level model
module tb_spi_txn_arbiter;

    localparam int N   = 2;
    localparam int LW  = 4;
    localparam int SSU = 2;
    localparam int SSH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*LW-1:0] req_len;
    logic [N*2-1:0]  req_mode;
    logic [N*8-1:0]  tx_data;
    logic [N-1:0]    grant, tx_ack, rx_valid, done, ss_n;
    logic [7:0]      rx_data, spi_din, spi_dout;
    logic            spi_cpol, spi_cpha, spi_start, spi_busy;

    spi_txn_arbiter #(.NREQ(N), .LENW(LW), .SS_SETUP(SSU), .SS_HOLD(SSH)) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_mode(req_mode),
        .tx_data(tx_data), .grant(grant), .tx_ack(tx_ack), .rx_valid(rx_valid),
        .rx_data(rx_data), .done(done), .ss_n(ss_n), .spi_cpol(spi_cpol),
        .spi_cpha(spi_cpha), .spi_din(spi_din), .spi_start(spi_start),
        .spi_busy(spi_busy), .spi_dout(spi_dout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    int          cyc = 0;
    bit          txn_on = 0;
    int          cur = 0, last_g = N - 1, exp_len = 0, n_ack = 0, n_rx = 0;
    int          t_grant = 0, t_fall = -1, t_rx = -1;
    bit          first_start = 0;
    logic [1:0]  exp_mode = 2'b00;
    logic        cpol_at_fall = 1'b0;
    logic [7:0]  exp_mosi[$], exp_miso[$], txq0[$], txq1[$], rsp_q[$];
    logic [7:0]  rx_log[$], mosi_log[$];
    int          grant_log[$];
    int          done_cnt[N];
    int          n_start = 0, n_fall = 0;
    logic [N-1:0] prev_ss = '1;
    logic        prev_start = 1'b0;
    logic [N-1:0]    req_s;
    logic [N*LW-1:0] len_s;
    logic [N*2-1:0]  mode_s;
    logic            busy_s, rst_s;
    bit          m_busy = 0;
    int          m_cnt = 0;
    logic [7:0]  m_resp = 8'h00;

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic load_lane(input int i);
        logic [7:0] v;
        if (i == 0 && txq0.size() > 0) v = txq0.pop_front();
        else if (i == 1 && txq1.size() > 0) v = txq1.pop_front();
        else v = 8'($urandom);
        tx_data[i*8 +: 8] = v;
    endtask

    // One clock: sample at negedge, compare with the model, then advance the master/slave model.
    task automatic step();
        int w;
        req_s = req; len_s = req_len; mode_s = req_mode; busy_s = spi_busy; rst_s = rst;
        @(negedge clk);
        cyc++;
        if (spi_start && !prev_start) n_start++;
        if (ss_n != {N{1'b1}} && prev_ss == {N{1'b1}}) n_fall++;
        if (rst_s) begin
            check("rst_pulses", {grant, tx_ack, rx_valid, done, spi_start}, '0);
            check("rst_ss_n", ss_n, {N{1'b1}});
            check("rst_data", {rx_data, spi_din, spi_cpol, spi_cpha}, '0);
            txn_on = 0; last_g = N - 1;
            exp_mosi.delete(); exp_miso.delete();
        end else if (!txn_on) begin
            if (req_s != '0 && !busy_s) begin
                w = rr_pick(req_s, last_g);
                if ((req_s & ~(N'(1) << last_g)) != '0) check("fair", w != last_g, 1);
                check("grant", grant, N'(1) << w);
                check("grant_mode", {spi_cpol, spi_cpha}, mode_s[w*2 +: 2]);
                check("grant_quiet", {ss_n, tx_ack, rx_valid, spi_start}, {{N{1'b1}}, {(2*N+1){1'b0}}});
                grant_log.push_back(w);
                cur = w; last_g = w;
                exp_len = int'(len_s[w*LW +: LW]);
                exp_mode = mode_s[w*2 +: 2];
                if (exp_len == 0) begin
                    check("len0_done", done, N'(1) << w);
                    done_cnt[w]++;
                end else begin
                    check("grant_no_done", done, '0);
                    txn_on = 1; n_ack = 0; n_rx = 0; t_grant = cyc; t_fall = -1; t_rx = -1;
                    first_start = 1;
                end
            end else begin
                check("idle", {grant, done, ss_n, tx_ack, rx_valid, spi_start},
                      {{(2*N){1'b0}}, {N{1'b1}}, {(2*N+1){1'b0}}});
            end
        end else if (done != '0) begin
            check("done", done, N'(1) << cur);
            check("done_acks", n_ack, exp_len);
            check("done_rx", n_rx, exp_len);
            check("hold_time", cyc - t_rx, SSH);
            check("done_ss", ss_n, {N{1'b1}});
            check("done_grant", grant, '0);
            done_cnt[cur]++;
            txn_on = 0;
        end else begin
            check("txn_grant", grant, N'(1) << cur);
            check("ss_sel", (ss_n == {N{1'b1}}) || (ss_n == ~(N'(1) << cur)), 1);
            if (ss_n != {N{1'b1}}) begin
                check("ss_mode", {spi_cpol, spi_cpha}, exp_mode);
                if (t_fall < 0) begin
                    t_fall = cyc;
                    cpol_at_fall = spi_cpol;
                    check("ss_setup", cyc - t_grant, SSU);
                end
            end else if (t_fall >= 0) begin
                check("ss_cont", ss_n, ~(N'(1) << cur));
            end
            if (spi_start && !prev_start && first_start) begin
                check("ss_to_start", cyc - t_fall, SSU);
                first_start = 0;
            end
            if (spi_start) check("start_ss", ss_n[cur], 0);
            if (tx_ack != '0) begin
                check("tx_ack", tx_ack, N'(1) << cur);
                n_ack++;
                exp_mosi.push_back(tx_data[cur*8 +: 8]);
                load_lane(cur);
            end
            if (rx_valid != '0) begin
                check("rx_valid", rx_valid, N'(1) << cur);
                n_rx++; t_rx = cyc;
                rx_log.push_back(rx_data);
                if (exp_miso.size() > 0) check("rx_data", rx_data, exp_miso.pop_front());
                else check("rx_unexpected", rx_valid, '0);
            end
            if (cyc - t_grant > 500) begin
                check("txn_timeout", txn_on, 0);
                txn_on = 0;
            end
        end
        prev_ss = ss_n;
        prev_start = spi_start;
        if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy = 0; spi_busy = 1'b0; spi_dout = m_resp;
                if (txn_on) exp_miso.push_back(m_resp);
            end
        end else if (spi_start) begin
            mosi_log.push_back(spi_din);
            if (exp_mosi.size() > 0) check("mosi", spi_din, exp_mosi.pop_front());
            else check("mosi_unexpected", spi_start, 0);
            m_busy = 1; m_cnt = int'($urandom_range(2, 7));
            if (rsp_q.size() > 0) m_resp = rsp_q.pop_front();
            else m_resp = 8'($urandom);
            spi_busy = 1'b1;
        end
    endtask

    task automatic run_txn(input int i, input bit hold, input int budget, output int cycles);
        int target;
        target = done_cnt[i] + 1;
        cycles = 0;
        while (done_cnt[i] < target && cycles < budget) begin
            step();
            cycles++;
            if (!hold && grant[i]) req[i] = 1'b0;
            if (done[i]) req[i] = 1'b0;
        end
        check("wait_done", done_cnt[i] >= target, 1);
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((txn_on || m_busy) && c < 1000) begin
            step();
            c++;
        end
        check("drain", txn_on, 0);
        step();
    endtask

    initial begin
        int c, g0, d0, nst, nfl;
        rst = 1'b1; req = '0; req_len = '0; req_mode = '0; tx_data = '0;
        spi_busy = 1'b0; spi_dout = '0;
        for (int i = 0; i < N; i++) done_cnt[i] = 0;
        repeat (3) step();
        rst = 1'b0;
        step();

        txq0.push_back(8'hA1); rsp_q.push_back(8'hB2); load_lane(0);
        req_len[0 +: LW] = LW'(1); req_mode[1:0] = 2'b00;
        rx_log.delete(); mosi_log.delete();
        req[0] = 1'b1;
        run_txn(0, 0, 300, c);
        check("t1_n_mosi", mosi_log.size(), 1);
        if (mosi_log.size() > 0) check("t1_mosi", mosi_log[0], 8'hA1);
        check("t1_n_rx", rx_log.size(), 1);
        if (rx_log.size() > 0) check("t1_rx", rx_log[0], 8'hB2);
        drain();

        txq1.push_back(8'h51); txq1.push_back(8'h52); txq1.push_back(8'h53);
        rsp_q.push_back(8'h61); rsp_q.push_back(8'h62); rsp_q.push_back(8'h63);
        load_lane(1);
        req_len[LW +: LW] = LW'(3); req_mode[3:2] = 2'b11;
        rx_log.delete(); mosi_log.delete();
        req[1] = 1'b1;
        run_txn(1, 0, 600, c);
        check("t2_n_rx", rx_log.size(), 3);
        for (int k = 0; k < 3 && k < rx_log.size(); k++) check("t2_rx", rx_log[k], 8'h61 + k);
        for (int k = 0; k < 3 && k < mosi_log.size(); k++) check("t2_mosi", mosi_log[k], 8'h51 + k);
        check("t2_cpol_at_fall", cpol_at_fall, 1);
        drain();

        req_len = {LW'(1), LW'(1)};
        g0 = grant_log.size();
        req = 2'b11;
        c = 0;
        while (grant_log.size() < g0 + 4 && c < 2000) begin
            step();
            c++;
        end
        req = '0;
        check("t3_n_grants", grant_log.size() >= g0 + 4, 1);
        for (int k = 0; k < 4 && g0 + k < grant_log.size(); k++) check("t3_alt", grant_log[g0 + k], k % 2);
        drain();

        nst = n_start; nfl = n_fall;
        req_len[0 +: LW] = '0;
        req[0] = 1'b1;
        run_txn(0, 0, 20, c);
        check("t4_latency", c <= 2, 1);
        check("t4_no_start", n_start, nst);
        check("t4_no_ss", n_fall, nfl);
        drain();

        req_len[0 +: LW] = LW'(3); req_mode[1:0] = 2'b01;
        req[0] = 1'b1;
        c = 0;
        while (!(txn_on && n_rx == 1 && m_busy) && c < 400) begin
            step();
            c++;
        end
        check("t5_reach_byte2", txn_on && n_rx == 1 && m_busy, 1);
        d0 = done_cnt[0];
        rst = 1'b1;
        step();
        rst = 1'b0;
        run_txn(0, 1, 600, c);
        check("t5_one_done", done_cnt[0], d0 + 1);
        drain();

        req_len[LW +: LW] = LW'(2); req_mode[3:2] = 2'b10;
        req[1] = 1'b1;
        run_txn(1, 0, 600, c);
        drain();

        for (int s = 0; s < 3000; s++) begin
            if ($urandom_range(0, 7) == 0) begin
                int i;
                i = int'($urandom_range(0, N - 1));
                req[i] = ~req[i];
                req_len[i*LW +: LW] = LW'($urandom_range(0, 5));
                req_mode[i*2 +: 2] = 2'($urandom);
            end
            rst = ($urandom_range(0, 799) == 0);
            step();
        end
        rst = 1'b0;
        req = '0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
Sequences multi-byte SPI transactions through one shared spi_master and arbitrates it between NREQ requesters. Each requester has its own active-low slave select and its own CPOL/CPHA mode. The block drives the master's din/start, consumes its busy/dout, and returns received bytes and a completion pulse to the granted requester.

Parameters:
NREQ, 2, number of requesters / slave selects (2..8)
LENW, 4, width of per-requester byte count (max 2^LENW-1 bytes)
SS_SETUP, 2, clk cycles between mode change and ss_n falling (also ss_n low to first start)
SS_HOLD, 2, clk cycles between last busy fall and ss_n rising

Ports:
clk  in  1  system clock, same clock as spi_master clk4
rst  in  1  synchronous active-high reset
req  in  NREQ  level request per requester
req_len  in  NREQ*LENW  byte count per requester, slice i = requester i
req_mode  in  NREQ*2  {cpol,cpha} per requester
tx_data  in  NREQ*8  next byte to send, per requester
grant  out  NREQ  one-hot, high for the whole transaction
tx_ack  out  NREQ  1-cycle pulse: tx_data consumed, present next byte
rx_valid  out  NREQ  1-cycle pulse: rx_data holds a received byte
rx_data  out  8  last received byte
done  out  NREQ  1-cycle pulse at end of transaction
ss_n  out  NREQ  active-low slave selects
spi_cpol  out  1  to master cpol
spi_cpha  out  1  to master cpha
spi_din  out  8  to master din
spi_start  out  1  to master start
spi_busy  in  1  from master busy
spi_dout  in  8  from master dout

Behaviour:
- Reset: grant=0, tx_ack=0, rx_valid=0, done=0, rx_data=0, ss_n=all 1, spi_start=0, spi_din=0, spi_cpol=0, spi_cpha=0, last-grant pointer=NREQ-1, state IDLE. Reset mid-transaction aborts immediately (ss_n high next edge); no done pulse.
- States: IDLE, SETUP, LOAD, WAIT_BUSY, SHIFT, HOLD.
- IDLE: when spi_busy=0 and any req=1, grant the first requester after the last-grant pointer, round-robin. The registered outputs grant, spi_cpol and spi_cpha update on that edge. Latch the requester's len into the counter. The pointer updates. If len=0: pulse done with grant for one cycle, ss_n untouched, return to IDLE. Otherwise go to SETUP.
- SETUP: ss_n stays high for SS_SETUP cycles, then ss_n[g] goes low. After a further SS_SETUP cycles, go to LOAD.
- LOAD (1 cycle): spi_din<=tx_data[g], spi_start<=1, tx_ack[g] pulse; go to WAIT_BUSY.
- WAIT_BUSY: hold spi_start=1 until spi_busy=1; on that cycle drop spi_start and go to SHIFT.
- SHIFT: on spi_busy=0, rx_data<=spi_dout, rx_valid[g] pulse, and decrement the counter. If the counter is now 0, go to HOLD; otherwise go to LOAD. Consecutive bytes keep ss_n low.
- HOLD: SS_HOLD cycles, then ss_n[g]<=1, done[g] pulse, grant<=0 on the same edge; go to IDLE. The earliest next grant is the following cycle.
- req deassertion mid-transaction is ignored; the transaction runs to its latched length. req_len, req_mode and other requesters' inputs are sampled only at grant.
- Fairness: a requester holding req continuously cannot be granted twice while another req is pending.
- Exactly one ss_n bit is low at any time; none is low outside SETUP-second-half..HOLD.
- spi_cpol/spi_cpha change only in IDLE while all ss_n are high.

Test Plan:
- Single requester 0, len=1, mode 00, tx 0xA1, slave model returns 0xB2 -> one tx_ack, rx_valid with rx_data=0xB2, slave sees 0xA1, done[0] pulse, ss_n[0] low only around the byte.
- Requester 1, len=3, mode 11, tx 0x51,0x52,0x53, slave returns 0x61,0x62,0x63 -> three rx_valid with those values in order, ss_n[1] continuously low, mclk idles high before ss_n falls.
- req=2'b11 held continuously, len=1 each -> grants alternate 0,1,0,1; no requester is granted twice in a row.
- len=0 on requester 0 -> done[0] pulse within 2 cycles, ss_n never falls, spi_start never asserts.
- rst pulsed during byte 2 of a 3-byte transfer -> ss_n all 1 next cycle, no done; the next grant waits until spi_busy=0, then a fresh transaction completes correctly.
- Requester drops req after grant in a 2-byte transfer -> both bytes still transferred, done pulsed.
